// File: rtl/data_mem_bridge_pkg.sv
// Shared types and helpers for the data-memory bridge: FSM states, access-size
// codes and the byte-enable generator.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] MS_NONE = 2'b00;
    localparam logic [1:0] MS_BYTE = 2'b01;
    localparam logic [1:0] MS_HALF = 2'b10;
    localparam logic [1:0] MS_WORD = 2'b11;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            MS_BYTE: be = 4'b0001 << addr_lo;
            MS_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            MS_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_bridge_if.sv
// Word-organised memory bus between the bridge (master) and the data SRAM/bus (slave).
interface data_mem_bridge_if #(
    parameter int ADDR_W = 30
);
    logic              mreq;
    logic              mwe;
    logic [ADDR_W-1:0] maddr;
    logic [3:0]        mbe;
    logic [31:0]       mwdata;
    logic              mack;
    logic [31:0]       mrdata;

    modport master (
        output mreq, mwe, maddr, mbe, mwdata,
        input  mack, mrdata
    );

    modport slave (
        input  mreq, mwe, maddr, mbe, mwdata,
        output mack, mrdata
    );
endinterface

// File: rtl/data_mem_bridge_lane_steer.sv
// Combinational lane steering: byte enables, lane-replicated store data and
// the alignment check for one CPU access.
module lane_steer
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign
);

    assign be       = be_gen(size, addr_lo);
    assign misalign = ((size == MS_HALF) && addr_lo[0]) ||
                      ((size == MS_WORD) && (addr_lo != 2'b00));

    // Each lane carries the source byte that would land there for its size.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_rep[8*gi +: 8] = (size == MS_BYTE) ? wdata[7:0] :
                                          (size == MS_HALF) ? wdata[8*(gi%2) +: 8] :
                                                              wdata[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/data_mem_bridge.sv
// CPU load/store bridge: captures one access, runs req/ack with a timeout
// watchdog, stalls the core and returns right-shifted load data.
module data_mem_bridge
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_write,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_wdata,
    input  logic [1:0]         i_memsize,
    output logic [31:0]        o_rdata,
    output logic               o_stall,
    output logic               o_misalign,
    output logic               o_err,
    data_mem_bridge_if.master  mem
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [WD_W-1:0]   wd_reg;
    logic              mreq_reg, mwe_reg, err_reg;
    logic [ADDR_W-1:0] maddr_reg;
    logic [3:0]        mbe_reg;
    logic [31:0]       mwdata_reg, rdata_reg;
    logic [1:0]        lo_reg;

    logic              wr_req, ld_req, req_valid, ack_hit, timeout_hit;
    logic              steer_mis;
    logic [3:0]        steer_be;
    logic [31:0]       steer_wdata;

    lane_steer u_steer (
        .size      (i_memsize),
        .addr_lo   (i_addr[1:0]),
        .wdata     (i_wdata),
        .be        (steer_be),
        .wdata_rep (steer_wdata),
        .misalign  (steer_mis)
    );

    // A store outranks a load whenever the CPU raises both.
    assign wr_req = i_write && (i_memsize != MS_NONE);
    assign ld_req = i_load && !i_write;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        o_stall     = 1'b0;
        o_misalign  = 1'b0;
        req_valid   = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by reset so a held request cannot stall the core during reset.
                if (i_rst_n && (wr_req || ld_req)) begin
                    if (steer_mis) begin
                        o_misalign = 1'b1;
                    end else begin
                        req_valid  = 1'b1;
                        o_stall    = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                o_stall = 1'b1;
                if (mem.mack) begin
                    ack_hit    = 1'b1;
                    state_next = DONE;
                end else if (wd_reg == WD_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mreq_reg   <= 1'b0;
            mwe_reg    <= 1'b0;
            maddr_reg  <= '0;
            mbe_reg    <= 4'b0000;
            mwdata_reg <= '0;
            lo_reg     <= 2'b00;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
            wd_reg     <= '0;
        end else begin
            err_reg <= timeout_hit;
            if (req_valid) begin
                mreq_reg   <= 1'b1;
                mwe_reg    <= wr_req;
                maddr_reg  <= i_addr[ADDR_W+1:2];
                mbe_reg    <= wr_req ? steer_be : 4'b1111;
                mwdata_reg <= steer_wdata;
                lo_reg     <= i_addr[1:0];
                wd_reg     <= '0;
            end else if (state_reg == REQ) begin
                if (ack_hit || timeout_hit) mreq_reg <= 1'b0;
                if (ack_hit && !mwe_reg)
                    rdata_reg <= mem.mrdata >> {lo_reg, 3'b000};
                else if (timeout_hit)
                    rdata_reg <= '0;
                if (!ack_hit && !timeout_hit) wd_reg <= wd_reg + 1'b1;
            end
        end
    end

    assign mem.mreq   = mreq_reg;
    assign mem.mwe    = mwe_reg;
    assign mem.maddr  = maddr_reg;
    assign mem.mbe    = mbe_reg;
    assign mem.mwdata = mwdata_reg;
    assign o_rdata    = rdata_reg;
    assign o_err      = err_reg;

endmodule
